// File: rtl/pio_pkg.sv
// Shared definitions for the pio host bridge: action codes, address map and FSM/decoder enums.
package pio_pkg;

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_PULL  = 4'd3;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;
  localparam logic [3:0] ACT_SIDES = 4'd8;
  localparam logic [3:0] ACT_IMM   = 4'd9;
  localparam logic [3:0] ACT_SHIFT = 4'd10;

  localparam logic [2:0] ADDR_INSTR_HI = 3'b000;     // 0x00-0x1F
  localparam logic [1:0] ADDR_CFG_HI   = 2'b01;      // 0x40-0x7F
  localparam logic [5:0] ADDR_PUSH_HI  = 6'b100000;  // 0x80-0x83
  localparam logic [7:0] ADDR_STATUS   = 8'h84;
  localparam logic [5:0] ADDR_PULL_HI  = 6'b110000;  // 0xC0-0xC3

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_WAIT_TX, ST_WAIT_RX, ST_ISSUE, ST_CAPTURE, ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    K_ILLEGAL, K_INSTR, K_CFG, K_PUSH, K_PULL, K_STATUS
  } kind_e;

  function automatic logic cfg_code_legal(input logic [3:0] c);
    case (c)
      ACT_PEND, ACT_GRPS, ACT_EN, ACT_DIV, ACT_SIDES, ACT_IMM, ACT_SHIFT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pio_bridge_decode.sv
// Combinational request classifier: address + direction -> request kind, action code, index.
module pio_bridge_decode
  import pio_pkg::*;
(
  input  logic [7:0] addr,
  input  logic       write,
  output kind_e      kind,
  output logic [3:0] code,
  output logic [4:0] idx,
  output logic       legal
);

  // Classify the latched request against the address map
  always_comb begin
    kind  = K_ILLEGAL;
    code  = ACT_NONE;
    idx   = 5'd0;
    legal = 1'b0;
    if (write && addr[7:5] == ADDR_INSTR_HI) begin
      kind  = K_INSTR;
      code  = ACT_INSTR;
      idx   = addr[4:0];
      legal = 1'b1;
    end else if (write && addr[7:6] == ADDR_CFG_HI && cfg_code_legal(addr[3:0])) begin
      kind  = K_CFG;
      code  = addr[3:0];
      idx   = {3'b000, addr[5:4]};
      legal = 1'b1;
    end else if (write && addr[7:2] == ADDR_PUSH_HI) begin
      kind  = K_PUSH;
      code  = ACT_PUSH;
      idx   = {3'b000, addr[1:0]};
      legal = 1'b1;
    end else if (!write && addr == ADDR_STATUS) begin
      kind  = K_STATUS;
      legal = 1'b1;
    end else if (!write && addr[7:2] == ADDR_PULL_HI) begin
      kind  = K_PULL;
      code  = ACT_PULL;
      idx   = {3'b000, addr[1:0]};
      legal = 1'b1;
    end else begin
      kind  = K_ILLEGAL;
    end
  end

endmodule

// File: rtl/pio_host_bridge.sv
// Host register interface to pio action strobes; one request in flight, one response per accept.
module pio_host_bridge
  import pio_pkg::*;
#(
  parameter int PULL_LAT = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic [3:0]  tx_full,
  input  logic [3:0]  rx_empty
);

  localparam logic [31:0] TIMEOUT_M1  = 32'(TIMEOUT - 1);
  localparam logic [31:0] PULL_LAT_M1 = 32'(PULL_LAT - 1);
  localparam logic        USE_TIMEOUT = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] lat_q, lat_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [3:0]  action_q, action_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  mindex_q, mindex_d;
  logic [31:0] din_q, din_d;

  kind_e       dec_kind;
  logic [3:0]  dec_code;
  logic [4:0]  dec_idx;
  logic        dec_legal;
  logic [1:0]  m_s;
  logic        go_issue_s;

  pio_bridge_decode u_decode (
    .addr  (addr_q),
    .write (write_q),
    .kind  (dec_kind),
    .code  (dec_code),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  assign m_s = dec_idx[1:0];

  // Next-state logic; all outputs are registered as they are loaded on entry to ISSUE/RESP
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    stall_d     = stall_q;
    lat_d       = lat_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'd0;
    go_issue_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (dec_kind == K_STATUS) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {24'd0, rx_empty, tx_full};
        end else if (dec_kind == K_PUSH) begin
          state_d = ST_WAIT_TX;
          stall_d = 32'd0;
        end else if (dec_kind == K_PULL) begin
          state_d = ST_WAIT_RX;
          stall_d = 32'd0;
        end else begin
          go_issue_s = 1'b1;
        end
      end
      ST_WAIT_TX, ST_WAIT_RX: begin
        if ((state_q == ST_WAIT_TX) ? !tx_full[m_s] : !rx_empty[m_s]) begin
          go_issue_s = 1'b1;
        end else if (USE_TIMEOUT && stall_q == TIMEOUT_M1) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          stall_d = stall_q + 32'd1;
        end
      end
      ST_ISSUE: begin
        if (dec_kind == K_PULL) begin
          state_d = ST_CAPTURE;
          lat_d   = 32'd0;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (lat_q == PULL_LAT_M1) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = dout;
        end else begin
          lat_d = lat_q + 32'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (go_issue_s) begin
      state_d  = ST_ISSUE;
      action_d = dec_code;
      index_d  = (dec_kind == K_INSTR) ? dec_idx : 5'd0;
      mindex_d = (dec_kind == K_INSTR) ? 2'd0 : m_s;
      din_d    = write_q ? wdata_q : 32'd0;
    end else begin
      action_d = ACT_NONE;
      index_d  = 5'd0;
      mindex_d = 2'd0;
      din_d    = 32'd0;
    end
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 8'd0;
      wdata_q     <= 32'd0;
      write_q     <= 1'b0;
      stall_q     <= 32'd0;
      lat_q       <= 32'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      action_q    <= ACT_NONE;
      index_q     <= 5'd0;
      mindex_q    <= 2'd0;
      din_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      stall_q     <= stall_d;
      lat_q       <= lat_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      action_q    <= action_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      din_q       <= din_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign action    = action_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign din       = din_q;

endmodule

// File: tb/tb_pio_host_bridge.sv
// Directed testbench for pio_host_bridge (PULL_LAT=1, TIMEOUT=8).
module tb_pio_host_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic [31:0] dout = 32'h0BAD0BAD;
  logic [3:0]  tx_full = 4'd0;
  logic [3:0]  rx_empty = 4'hF;

  always #5 clk = ~clk;

  pio_host_bridge #(.PULL_LAT(1), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .action(action), .index(index), .mindex(mindex), .din(din),
    .dout(dout), .tx_full(tx_full), .rx_empty(rx_empty)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  int          r_lat, r_nact, r_actcyc, r_rdywait;
  logic        r_err;
  logic [31:0] r_rdata, r_din;
  logic [3:0]  r_act;
  logic [4:0]  r_idx;
  logic [1:0]  r_midx;

  // Issue one request and observe it until the response (or a 40-cycle bound).
  // r_lat counts cycles from the accept edge; -1 = no response, -2 = never ready.
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input int chg_cyc, input logic [3:0] chg_tx, input logic [3:0] chg_rx);
    int pull_cyc;
    r_lat = -1; r_err = 1'b0; r_rdata = 32'd0; r_nact = 0; r_act = 4'd0;
    r_idx = 5'd0; r_midx = 2'd0; r_din = 32'd0; r_actcyc = 0; r_rdywait = 0;
    pull_cyc = -10;
    while (req_ready !== 1'b1 && r_rdywait < 50) begin
      @(negedge clk);
      r_rdywait++;
    end
    if (req_ready !== 1'b1) begin
      r_lat = -2;
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'd0; req_wdata = 32'd0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (action !== 4'd0) begin
        r_nact++; r_act = action; r_idx = index; r_midx = mindex; r_din = din; r_actcyc = cyc;
        if (action === 4'd3) pull_cyc = cyc;
      end
      if (rsp_valid === 1'b1) begin
        r_lat = cyc; r_err = rsp_err; r_rdata = rsp_rdata;
        break;
      end
      if (cyc == chg_cyc) begin
        tx_full = chg_tx; rx_empty = chg_rx;
      end
      if (cyc == pull_cyc) dout = 32'hDEADBEEF;
      else if (cyc == pull_cyc + 2) dout = 32'h0BAD0BAD;
      @(negedge clk);
    end
    dout = 32'h0BAD0BAD;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, action, index, mindex, din} !== 78'd0)
      $display("FAIL reset_outputs: got ready=%b valid=%b action=%0d din=%h, expected all 0",
               req_ready, rsp_valid, action, din);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_push();
    int nrsp, nact;
    tx_full = 4'b0001;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h80; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, action, index, mindex, din} !== 78'd0)
      $display("FAIL midreset_outputs: got ready=%b valid=%b action=%0d, expected all 0",
               req_ready, rsp_valid, action);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tx_full = 4'd0;
    nrsp = 0; nact = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) nrsp++;
      if (action !== 4'd0) nact++;
    end
    total_cnt++;
    if (nrsp != 0 || nact != 0) $display("FAIL midreset_quiet: got rsp=%0d act=%0d expected 0/0", nrsp, nact);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_instr();
    do_req(1'b1, 8'h03, 32'h00001234, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 3 || r_err !== 1'b0 || r_rdata !== 32'd0)
      $display("FAIL instr_rsp: got lat=%0d err=%b rdata=%h expected 3/0/0", r_lat, r_err, r_rdata);
    else pass_cnt++;
    total_cnt++;
    if (r_nact != 1 || r_actcyc != 2 || r_act !== 4'd1 || r_idx !== 5'd3 || r_midx !== 2'd0 || r_din !== 32'h1234)
      $display("FAIL instr_action: got n=%0d cyc=%0d act=%0d idx=%0d m=%0d din=%h expected 1/2/1/3/0/1234",
               r_nact, r_actcyc, r_act, r_idx, r_midx, r_din);
    else pass_cnt++;
  endtask

  task automatic test_config();
    do_req(1'b1, 8'h56, 32'd1, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 3 || r_err !== 1'b0 || r_nact != 1 || r_act !== 4'd6 || r_midx !== 2'd1 || r_idx !== 5'd0 || r_din !== 32'd1)
      $display("FAIL cfg_en: got lat=%0d err=%b n=%0d act=%0d m=%0d idx=%0d din=%h expected 3/0/1/6/1/0/1",
               r_lat, r_err, r_nact, r_act, r_midx, r_idx, r_din);
    else pass_cnt++;
    do_req(1'b1, 8'h53, 32'd7, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 2 || r_err !== 1'b1 || r_nact != 0 || r_rdata !== 32'd0)
      $display("FAIL cfg_illegal: got lat=%0d err=%b n=%0d rdata=%h expected 2/1/0/0", r_lat, r_err, r_nact, r_rdata);
    else pass_cnt++;
  endtask

  task automatic test_bad_addr();
    do_req(1'b0, 8'h03, 32'd0, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 2 || r_err !== 1'b1 || r_nact != 0)
      $display("FAIL read_of_instr: got lat=%0d err=%b n=%0d expected 2/1/0", r_lat, r_err, r_nact);
    else pass_cnt++;
    do_req(1'b1, 8'h84, 32'd9, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 2 || r_err !== 1'b1 || r_nact != 0)
      $display("FAIL write_of_status: got lat=%0d err=%b n=%0d expected 2/1/0", r_lat, r_err, r_nact);
    else pass_cnt++;
    do_req(1'b1, 8'h20, 32'd9, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 2 || r_err !== 1'b1 || r_nact != 0)
      $display("FAIL unmapped_20: got lat=%0d err=%b n=%0d expected 2/1/0", r_lat, r_err, r_nact);
    else pass_cnt++;
  endtask

  task automatic test_status();
    tx_full = 4'b0101; rx_empty = 4'b1010;
    do_req(1'b0, 8'h84, 32'd0, 0, 4'b0101, 4'b1010);
    total_cnt++;
    if (r_lat != 2 || r_err !== 1'b0 || r_rdata !== 32'h000000A5 || r_nact != 0)
      $display("FAIL status: got lat=%0d err=%b rdata=%h n=%0d expected 2/0/000000a5/0", r_lat, r_err, r_rdata, r_nact);
    else pass_cnt++;
    tx_full = 4'd0; rx_empty = 4'hF;
  endtask

  task automatic test_push_stall();
    tx_full = 4'b0001;
    do_req(1'b1, 8'h80, 32'h000000A5, 7, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 9 || r_err !== 1'b0)
      $display("FAIL push_stall_rsp: got lat=%0d err=%b expected 9/0", r_lat, r_err);
    else pass_cnt++;
    total_cnt++;
    if (r_nact != 1 || r_actcyc != 8 || r_act !== 4'd4 || r_midx !== 2'd0 || r_din !== 32'hA5)
      $display("FAIL push_stall_action: got n=%0d cyc=%0d act=%0d m=%0d din=%h expected 1/8/4/0/a5",
               r_nact, r_actcyc, r_act, r_midx, r_din);
    else pass_cnt++;
  endtask

  task automatic test_pull();
    rx_empty = 4'b1011;
    do_req(1'b0, 8'hC2, 32'd0, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 5 || r_err !== 1'b0 || r_rdata !== 32'hDEADBEEF)
      $display("FAIL pull_rsp: got lat=%0d err=%b rdata=%h expected 5/0/deadbeef", r_lat, r_err, r_rdata);
    else pass_cnt++;
    total_cnt++;
    if (r_nact != 1 || r_actcyc != 3 || r_act !== 4'd3 || r_midx !== 2'd2 || r_din !== 32'd0)
      $display("FAIL pull_action: got n=%0d cyc=%0d act=%0d m=%0d din=%h expected 1/3/3/2/0",
               r_nact, r_actcyc, r_act, r_midx, r_din);
    else pass_cnt++;
    rx_empty = 4'hF;
  endtask

  task automatic test_timeout();
    rx_empty = 4'hF;
    do_req(1'b0, 8'hC0, 32'd0, 0, 4'd0, 4'hF);
    total_cnt++;
    if (r_lat != 10 || r_err !== 1'b1 || r_rdata !== 32'd0 || r_nact != 0)
      $display("FAIL pull_timeout: got lat=%0d err=%b rdata=%h n=%0d expected 10/1/0/0", r_lat, r_err, r_rdata, r_nact);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tx_full = 4'b1000;
    do_req(1'b1, 8'h80, 32'h11, 0, 4'b1000, 4'hF);
    total_cnt++;
    if (r_lat != 4 || r_err !== 1'b0 || r_act !== 4'd4 || r_din !== 32'h11)
      $display("FAIL b2b_push: got lat=%0d err=%b act=%0d din=%h expected 4/0/4/11", r_lat, r_err, r_act, r_din);
    else pass_cnt++;
    do_req(1'b1, 8'h1F, 32'h22, 0, 4'b1000, 4'hF);
    total_cnt++;
    if (r_rdywait != 1 || r_lat != 3 || r_act !== 4'd1 || r_idx !== 5'd31)
      $display("FAIL b2b_instr: got wait=%0d lat=%0d act=%0d idx=%0d expected 1/3/1/31", r_rdywait, r_lat, r_act, r_idx);
    else pass_cnt++;
    do_req(1'b1, 8'h7A, 32'h33, 0, 4'b1000, 4'hF);
    total_cnt++;
    if (r_rdywait != 1 || r_lat != 3 || r_act !== 4'd10 || r_midx !== 2'd3 || r_din !== 32'h33)
      $display("FAIL b2b_shift: got wait=%0d lat=%0d act=%0d m=%0d din=%h expected 1/3/10/3/33",
               r_rdywait, r_lat, r_act, r_midx, r_din);
    else pass_cnt++;
    tx_full = 4'd0;
  endtask

  initial begin
    test_reset();
    test_instr();
    test_config();
    test_bad_addr();
    test_status();
    test_push_stall();
    test_pull();
    test_timeout();
    test_back_to_back();
    test_reset_mid_push();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
